fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be asynchronous and active-high.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous active-high reset
- pc  in  32  current PC value from the program counter
- npc  in  32  sequential next PC (pc+4) from the program counter
- PCen  out  1  PC load enable to the program counter
- cpc  out  32  value the PC loads when PCen=1
- iREN  out  1  instruction memory read request
- iaddr  out  32  instruction memory address
- ihit  in  1  instruction memory read complete (data valid on iload)
- iload  in  32  instruction memory read data
- instr  out  32  fetched instruction to decode
- instr_valid  out  1  instr holds a valid instruction
- id_ready  in  1  decode accepts instr this cycle
- redirect  in  1  branch/jump taken; refetch from redirect_addr
- redirect_addr  in  32  branch/jump target
- halt  in  1  halt instruction decoded
- halted  out  1  fetch stopped permanently

Function
REQ-003 The FSM SHALL have four states: IDLE, REQ, HOLD, HALT.
REQ-004 IDLE SHALL hold iREN=0 and PCen=0, and SHALL transition to REQ on the next edge unconditionally.
REQ-005 In REQ, iREN SHALL be 1 and iaddr SHALL equal pc combinationally.
REQ-006 REQ with ihit=1 and no redirect/halt SHALL, in the same cycle, drive PCen=1 and cpc=npc; on the edge it SHALL capture instr<=iload, set instr_valid=1 and move to HOLD.
REQ-007 REQ with ihit=0 SHALL stay in REQ with PCen=0 and iaddr stable.
REQ-008 HOLD SHALL keep instr and instr_valid=1 stable with iREN=0 and PCen=0 until id_ready=1; then instr_valid SHALL clear on the edge and the FSM SHALL return to REQ.
REQ-009 Load-to-use latency SHALL be one cycle (instr_valid rises the edge after ihit), and peak throughput SHALL be one instruction per two cycles.
REQ-010 Redirect SHALL be honoured in IDLE/REQ/HOLD: same cycle PCen=1, cpc={redirect_addr[31:2],2'b00}, iREN=0; next edge instr_valid=0, state=REQ.
REQ-011 An ihit coinciding with redirect SHALL be discarded (instr not updated), and PCen SHALL carry the redirect target, not npc.
REQ-012 When PCen=0, cpc SHALL equal npc.
REQ-013 halt=1 in any state SHALL move to HALT on the next edge and take priority over redirect and ihit in that cycle: PCen=0, instr unchanged.
REQ-014 HALT SHALL drive halted=1, iREN=0, PCen=0 and instr_valid=0, and SHALL remain there until RST.
REQ-015 PCen SHALL be asserted for at most one cycle per fetched instruction or redirect; the PC SHALL never advance twice for one instruction.

Reset
REQ-016 While RST=1: state=IDLE, PCen=0, iREN=0, instr=0, instr_valid=0, halted=0, and all counters=0, asynchronously.
REQ-017 RST asserted mid-REQ or mid-HOLD SHALL abandon the outstanding request and drop instr_valid immediately; the first request after RST deassertion SHALL occur two cycles later (via IDLE).

Configuration
REQ-018 Macro FETCH_STATS_EN SHALL gate two extra 32-bit outputs, fetch_count (increments on each accepted ihit per REQ-006) and stall_count (increments each cycle in REQ with ihit=0), both wrapping at 2^32-1 to 0 and frozen in HALT.
REQ-019 Without FETCH_STATS_EN, those ports and counters SHALL NOT exist and all other behaviour SHALL be identical.

Verification
REQ-020 Reset release, pc=0x0, npc=0x4, ihit=1 in the 1st REQ cycle -> iREN=1 at cycle 2, PCen=1 and cpc=0x4 that cycle, instr=iload=0x2002000A and instr_valid=1 at cycle 3.
REQ-021 ihit held low 5 cycles in REQ -> iaddr stable, PCen=0 throughout; stall_count=5 (FETCH_STATS_EN).
REQ-022 HOLD with id_ready=0 for 3 cycles then 1 -> instr stable 4 cycles, instr_valid drops next edge, iREN=1 again.
REQ-023 redirect=1, redirect_addr=0x00000103, ihit=1 same cycle -> PCen=1, cpc=0x00000100, instr unchanged, instr_valid=0 next cycle.
REQ-024 halt=1 with redirect=1 and ihit=1 -> PCen=0; next cycle halted=1, iREN=0, remains until RST.
REQ-025 RST pulsed while in HOLD -> instr_valid=0 and instr=0 asynchronously, iREN resumes two cycles after release.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: requests one instruction at a time, holds it for decode,
// and handles redirect, halt and reset. Define FETCH_STATS_EN to add fetch/stall counters.
module fetch_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] pc,
    input  logic [31:0] npc,
    output logic        PCen,
    output logic [31:0] cpc,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        id_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    input  logic        halt,
    output logic        halted
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    // state | meaning
    // IDLE  | one quiet cycle after reset before the first request
    // REQ   | read request outstanding at iaddr = pc
    // HOLD  | instruction presented to decode, waiting for id_ready
    // HALT  | fetch stopped until reset
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        HOLD = 2'b10,
        HALT = 2'b11
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        take_hit;
    logic [31:0] redirect_tgt;

    assign redirect_tgt = redirect_addr & ~32'h0000_0003;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // halt outranks redirect, which outranks a coincident ihit
    always_comb begin
        state_nxt = state;
        PCen      = 1'b0;
        cpc       = npc;
        iREN      = 1'b0;
        iaddr     = pc;
        take_hit  = 1'b0;
        halted    = 1'b0;
        case (state)
            IDLE: begin
                if (halt) begin
                    state_nxt = HALT;
                end else begin
                    state_nxt = REQ;
                    if (redirect) begin
                        PCen = 1'b1;
                        cpc  = redirect_tgt;
                    end
                end
            end
            REQ: begin
                if (halt) begin
                    state_nxt = HALT;
                end else if (redirect) begin
                    PCen      = 1'b1;
                    cpc       = redirect_tgt;
                    state_nxt = REQ;
                end else begin
                    iREN = 1'b1;
                    if (ihit) begin
                        PCen      = 1'b1;
                        take_hit  = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (halt) begin
                    state_nxt = HALT;
                end else if (redirect) begin
                    PCen      = 1'b1;
                    cpc       = redirect_tgt;
                    state_nxt = REQ;
                end else if (id_ready) begin
                    state_nxt = REQ;
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            instr <= 32'h0;
        end else if (take_hit) begin
            instr <= iload;
        end
    end

    // valid exactly while the FSM sits in HOLD
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            instr_valid <= 1'b0;
        end else begin
            instr_valid <= (state_nxt == HOLD);
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_count <= 32'h0;
            stall_count <= 32'h0;
        end else begin
            if (take_hit) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if ((state == REQ) && !ihit) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with an instruction scoreboard.
// Define FETCH_STATS_EN to also check the statistics counters.
module tb_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        PCen;
    logic [31:0] cpc;
    logic        iREN;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] iload;
    logic [31:0] instr;
    logic        instr_valid;
    logic        id_ready;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        halt;
    logic        halted;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    fetch_ctrl dut (
        .CLK(CLK),
        .RST(RST),
        .pc(pc),
        .npc(npc),
        .PCen(PCen),
        .cpc(cpc),
        .iREN(iREN),
        .iaddr(iaddr),
        .ihit(ihit),
        .iload(iload),
        .instr(instr),
        .instr_valid(instr_valid),
        .id_ready(id_ready),
        .redirect(redirect),
        .redirect_addr(redirect_addr),
        .halt(halt),
        .halted(halted)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count(fetch_count),
        .stall_count(stall_count)
`endif
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed %h expected <scoreboard empty>", tag, instr);
        end else begin
            e = exp_q.pop_front();
            chk(tag, instr, e);
        end
    endtask

    initial begin
        RST = 1'b1; pc = 32'h0; npc = 32'h4; ihit = 1'b0; iload = 32'h0;
        id_ready = 1'b0; redirect = 1'b0; redirect_addr = 32'h0; halt = 1'b0;
        #2;
        chk("rst_pcen", PCen, 0);
        chk("rst_iren", iREN, 0);
        chk("rst_instr", instr, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_halted", halted, 0);
`ifdef FETCH_STATS_EN
        chk("rst_fetch_cnt", fetch_count, 0);
        chk("rst_stall_cnt", stall_count, 0);
`endif
        tick();
        tick();

        // first fetch: IDLE then REQ with immediate hit
        RST = 1'b0; ihit = 1'b1; iload = 32'h2002000A;
        settle();
        chk("idle_iren", iREN, 0);
        chk("idle_pcen", PCen, 0);
        tick();
        settle();
        chk("req1_iren", iREN, 1);
        chk("req1_iaddr", iaddr, 32'h0);
        chk("req1_pcen", PCen, 1);
        chk("req1_cpc", cpc, 32'h4);
        chk("req1_valid", instr_valid, 0);
        exp_q.push_back(iload);
        tick();
        ihit = 1'b0; pc = 32'h4; npc = 32'h8;
        settle();
        chk("hold1_valid", instr_valid, 1);
        pop_chk("hold1_instr");
        chk("hold1_pcen", PCen, 0);
        chk("hold1_iren", iREN, 0);

        // decode stalls three cycles
        for (int i = 0; i < 3; i++) begin
            chk("hold_stable_instr", instr, 32'h2002000A);
            chk("hold_stable_valid", instr_valid, 1);
            chk("hold_stable_iren", iREN, 0);
            tick();
        end
        id_ready = 1'b1;
        settle();
        chk("hold4_instr", instr, 32'h2002000A);
        chk("hold4_valid", instr_valid, 1);
        tick();
        id_ready = 1'b0;
        settle();
        chk("rel_valid", instr_valid, 0);
        chk("rel_iren", iREN, 1);

        // five miss cycles in REQ
        for (int i = 0; i < 5; i++) begin
            chk("stall_iaddr", iaddr, 32'h4);
            chk("stall_pcen", PCen, 0);
            chk("stall_cpc", cpc, 32'h8);
            tick();
        end
`ifdef FETCH_STATS_EN
        chk("stall_cnt5", stall_count, 5);
`endif
        ihit = 1'b1; iload = 32'hDEADBEEF;
        settle();
        chk("req2_pcen", PCen, 1);
        chk("req2_cpc", cpc, 32'h8);
        exp_q.push_back(iload);
        tick();
        ihit = 1'b0; pc = 32'h8; npc = 32'hC;
        settle();
        pop_chk("hold2_instr");
`ifdef FETCH_STATS_EN
        chk("fetch_cnt2", fetch_count, 2);
`endif
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;

        // redirect colliding with ihit in REQ
        ihit = 1'b1; iload = 32'h11111111; redirect = 1'b1; redirect_addr = 32'h00000103;
        settle();
        chk("redir_pcen", PCen, 1);
        chk("redir_cpc", cpc, 32'h00000100);
        chk("redir_iren", iREN, 0);
        tick();
        redirect = 1'b0; ihit = 1'b0; pc = 32'h100; npc = 32'h104;
        settle();
        chk("redir_valid", instr_valid, 0);
        chk("redir_instr", instr, 32'hDEADBEEF);
        chk("redir_iren_next", iREN, 1);
        chk("redir_iaddr", iaddr, 32'h100);

        // fetch then redirect from HOLD
        ihit = 1'b1; iload = 32'h22222222;
        settle();
        chk("req3_cpc", cpc, 32'h104);
        exp_q.push_back(iload);
        tick();
        ihit = 1'b0; pc = 32'h104; npc = 32'h108;
        settle();
        pop_chk("hold3_instr");
        redirect = 1'b1; redirect_addr = 32'h00000200;
        settle();
        chk("hredir_pcen", PCen, 1);
        chk("hredir_cpc", cpc, 32'h200);
        tick();
        redirect = 1'b0; pc = 32'h200; npc = 32'h204;
        settle();
        chk("hredir_valid", instr_valid, 0);
        chk("hredir_iren", iREN, 1);
        chk("hredir_instr", instr, 32'h22222222);

        // reset while holding an instruction
        ihit = 1'b1; iload = 32'h33333333;
        settle();
        exp_q.push_back(iload);
        tick();
        ihit = 1'b0;
        settle();
        pop_chk("hold4_instr_sb");
        RST = 1'b1;
        #1;
        chk("arst_valid", instr_valid, 0);
        chk("arst_instr", instr, 0);
        chk("arst_iren", iREN, 0);
        chk("arst_pcen", PCen, 0);
        tick();
        RST = 1'b0;
        settle();
        chk("post_rst_idle_iren", iREN, 0);
        tick();
        settle();
        chk("post_rst_req_iren", iREN, 1);
        chk("post_rst_iaddr", iaddr, 32'h200);

        // halt beats redirect and ihit
        halt = 1'b1; redirect = 1'b1; redirect_addr = 32'h300; ihit = 1'b1; iload = 32'h44444444;
        settle();
        chk("halt_pcen", PCen, 0);
        chk("halt_cpc", cpc, 32'h204);
        tick();
        halt = 1'b0;
        settle();
        chk("halted", halted, 1);
        chk("halted_iren", iREN, 0);
        chk("halted_valid", instr_valid, 0);
        chk("halted_instr", instr, 0);
        for (int i = 0; i < 3; i++) begin
            ihit = (i % 2 == 0);
            settle();
            chk("halt_stay", halted, 1);
            chk("halt_stay_pcen", PCen, 0);
            tick();
        end
`ifdef FETCH_STATS_EN
        chk("halt_fetch_cnt", fetch_count, 0);
`endif
        chk("sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
